// File: rtl/mem_port_arbiter4.sv
// Round-robin arbiter/sequencer sharing one memory port among four requesters.
// Optional watchdog in the ISSUE state is enabled with `define ARB_TIMEOUT_EN.
module mem_port_arbiter4 #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               mem_ack,
  output logic [1:0]         slct,
  output logic [NUM_REQ-1:0] grant,
  output logic               mem_req,
  output logic [NUM_REQ-1:0] ack,
  output logic [NUM_REQ-1:0] err,
  output logic               busy
);

  if (NUM_REQ != 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("mem_port_arbiter4: NUM_REQ must be 4 and TIMEOUT_CYCLES in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_RELEASE = 2'b10
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_slct, w_slct_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_mem_req, w_mem_req_nxt;
  logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0] r_err, w_err_nxt;
  logic               r_busy, w_busy_nxt;
  logic [1:0]         r_last, w_last_nxt;
  logic [1:0]         w_win;
  logic               w_timeout;

  // Nearest set bit after 'last' wins; scanning farthest-first lets the nearest overwrite.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign w_win = rr_pick(req, r_last);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Count stays at zero outside ISSUE, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != S_ISSUE) begin
      r_cnt <= '0;
    end else if (!mem_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_state == S_ISSUE) && !mem_ack && (r_cnt == 8'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_slct_nxt    = r_slct;
    w_grant_nxt   = r_grant;
    w_mem_req_nxt = r_mem_req;
    w_ack_nxt     = '0;
    w_err_nxt     = '0;
    w_busy_nxt    = r_busy;
    w_last_nxt    = r_last;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nxt   = S_ISSUE;
          w_slct_nxt    = w_win;
          w_grant_nxt   = onehot(w_win);
          w_mem_req_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      S_ISSUE: begin
        if (mem_ack || w_timeout) begin
          w_state_nxt   = S_RELEASE;
          w_mem_req_nxt = 1'b0;
          w_grant_nxt   = '0;
          w_ack_nxt     = onehot(r_slct);
          w_err_nxt     = w_timeout ? onehot(r_slct) : '0;
          w_last_nxt    = r_slct;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_slct_nxt    = '0;
        w_grant_nxt   = '0;
        w_mem_req_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_slct    <= '0;
      r_grant   <= '0;
      r_mem_req <= 1'b0;
      r_ack     <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_last    <= 2'd3;
    end else begin
      r_state   <= w_state_nxt;
      r_slct    <= w_slct_nxt;
      r_grant   <= w_grant_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign slct    = r_slct;
  assign grant   = r_grant;
  assign mem_req = r_mem_req;
  assign ack     = r_ack;
  assign err     = r_err;
  assign busy    = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Bench for mem_port_arbiter4: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mem_ack;
  logic [1:0] slct;
  logic [3:0] grant, ack, err;
  logic       mem_req, busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter4 #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mem_ack(mem_ack),
    .slct(slct), .grant(grant), .mem_req(mem_req), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is idle / issuing / releasing, with a winner and
  // the last winner remembered for round-robin.
  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  int m_phase = 0;  // 0 idle, 1 issuing, 2 releasing
  int m_win   = 0;
  int m_last  = 3;
  int m_slct  = 0;
  int m_wait  = 0;
  bit m_err   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_last <= 3; m_slct <= 0; m_wait <= 0; m_err <= 1'b0; m_win <= 0;
    end else begin
      case (m_phase)
        0: if (req != 4'b0) begin
             m_win   <= rr_pick(req, m_last);
             m_slct  <= rr_pick(req, m_last);
             m_phase <= 1;
             m_wait  <= 0;
           end
        1: begin
             m_wait <= m_wait + 1;
             if (mem_ack) begin
               m_phase <= 2; m_last <= m_win; m_err <= 1'b0;
             end else if (TO_ON && m_wait == TO) begin
               m_phase <= 2; m_last <= m_win; m_err <= 1'b1;
             end
           end
        default: begin
          m_phase <= 0; m_err <= 1'b0;
        end
      endcase
    end
  end

  logic [1:0] e_slct;
  logic [3:0] e_grant, e_ack, e_err;
  logic       e_mem_req, e_busy;
  always_comb begin
    e_slct    = 2'(m_slct);
    e_grant   = (m_phase == 1) ? (4'b1 << m_win) : 4'b0;
    e_mem_req = (m_phase == 1);
    e_ack     = (m_phase == 2) ? (4'b1 << m_last) : 4'b0;
    e_err     = (m_phase == 2 && m_err) ? (4'b1 << m_last) : 4'b0;
    e_busy    = (m_phase != 0);
  end

  always @(negedge clk) begin
    chk("model_slct", 32'(slct), 32'(e_slct));
    chk("model_grant", 32'(grant), 32'(e_grant));
    chk("model_mem_req", 32'(mem_req), 32'(e_mem_req));
    chk("model_ack", 32'(ack), 32'(e_ack));
    chk("model_err", 32'(err), 32'(e_err));
    chk("model_busy", 32'(busy), 32'(e_busy));
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nr;
    logic [3:0] seen [5];
    int         at [5];
    logic [3:0] exp_seq [5];
    int         na, n, lows;

    rst_n = 1'b0; req = 4'hf; mem_ack = 1'b0;
    tick(); tick(); tick();
    chk("rst_slct", 32'(slct), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);

    rst_n = 1'b1;
    tick();
    chk("first_grant", 32'(grant), 32'h1);
    chk("first_mem_req", 32'(mem_req), 1);
    req = 4'h0;  // winner drops its request mid-transaction
    tick(); tick();
    chk("drop_grant_held", 32'(grant), 32'h1);
    mem_ack = 1'b1;
    tick();
    chk("drop_ack", 32'(ack), 32'h1);
    mem_ack = 1'b0;
    tick();
    chk("drop_idle_busy", 32'(busy), 0);

    req = 4'b0100;
    tick();
    chk("s3_mem_req", 32'(mem_req), 1);
    chk("s3_slct", 32'(slct), 2);
    chk("s3_grant", 32'(grant), 32'h4);
    tick(); tick();
    mem_ack = 1'b1;
    tick();
    chk("s3_ack", 32'(ack), 32'h4);
    chk("s3_mem_req_low", 32'(mem_req), 0);
    mem_ack = 1'b0; req = 4'b0;
    tick();
    chk("s3_busy", 32'(busy), 0);
    chk("s3_ack_gone", 32'(ack), 0);

    exp_seq[0] = 4'b1000; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b0100; exp_seq[4] = 4'b1000;
    for (int i = 0; i < 5; i++) begin seen[i] = 4'b0; at[i] = 0; end
    na = 0;
    req = 4'hf; mem_ack = 1'b1;
    for (int c = 0; c < 40 && na < 5; c++) begin
      tick();
      if (ack != 4'b0) begin seen[na] = ack; at[na] = c; na++; end
    end
    chk("fair_count", 32'(na), 5);
    for (int i = 0; i < 5; i++) chk("fair_ack", 32'(seen[i]), 32'(exp_seq[i]));
    for (int i = 1; i < 5; i++) chk("fair_gap", 32'(at[i] - at[i-1]), 3);
    req = 4'b0; mem_ack = 1'b0;
    tick();

    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_ack_ignored", 32'(ack), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_slct_kept", 32'(slct), 3);
    end
    mem_ack = 1'b0;

    req = 4'b0001;
    tick();
    chk("pre_rst_grant", 32'(grant), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 0);
    chk("async_rst_grant", 32'(grant), 0);
    @(negedge clk);
    req = 4'b1000; rst_n = 1'b1;
    tick();
    chk("post_rst_grant", 32'(grant), 32'h8);
    mem_ack = 1'b1;
    tick();
    chk("post_rst_ack", 32'(ack), 32'h8);
    mem_ack = 1'b0; req = 4'b0;
    tick();

    req = 4'b0010;
    tick();
    chk("wd_mem_req", 32'(mem_req), 1);
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (ack == 4'b0 && n < 50) begin tick(); n++; end
    chk("wd_latency", 32'(n), 5);
    chk("wd_ack", 32'(ack), 32'h2);
    chk("wd_err", 32'(err), 32'h2);
    req = 4'b0;
    tick();
`else
    lows = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (mem_req !== 1'b1) lows++;
    end
    chk("no_wd_mem_req_held", 32'(lows), 0);
    mem_ack = 1'b1;
    tick();
    chk("no_wd_ack", 32'(ack), 32'h2);
    mem_ack = 1'b0; req = 4'b0;
    tick();
`endif

    for (int c = 0; c < 2000; c++) begin
      nr = req;
      for (int i = 0; i < 4; i++) begin
        if (e_ack[i]) nr[i] = 1'b0;
        else if (!nr[i] && ($urandom % 4) == 0) nr[i] = 1'b1;
        else if (nr[i] && m_phase == 1 && m_win == i && ($urandom % 64) == 0) nr[i] = 1'b0;
      end
      req     = nr;
      mem_ack = (($urandom % 3) == 0);
      tick();
    end
    req = 4'b0; mem_ack = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter4.md
Name: mem_port_arbiter4

Overview:
- Round-robin arbiter and sequencer for one shared memory port used by four requesters, e.g. instruction fetch, load, store and debug.
- Chooses one requester at a time and drives the 2-bit select of the mux4x1 instances that steer that requester's addr/wdata/we onto the port.
- Runs the req/ack handshake with the memory and returns a one-hot ack to the winner.
- Control only: the datapath muxes sit outside this block.

Parameters:
- NUM_REQ, 4: number of requesters. Fixed at 4 to match the 2-bit mux select; any other value is unsupported.
- TIMEOUT_CYCLES, 255: watchdog limit in ISSUE state, in cycles. Used only with ARB_TIMEOUT_EN; range 1..255.

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester. Must be held high until that requester's ack pulse.
- mem_ack  input  1  memory completion; sampled only in ISSUE state.
- slct  output  2  select for the external mux4x1 instances; the encoded index of the granted requester.
- grant  output  4  one-hot grant, high for the whole of ISSUE state.
- mem_req  output  1  request to memory, high for the whole of ISSUE state.
- ack  output  4  one-hot completion pulse to the winner, one cycle long.
- err  output  4  one-hot timeout flag, pulses together with ack. Tied to 0 without ARB_TIMEOUT_EN.
- busy  output  1  high in ISSUE and RELEASE states.

Behaviour:
- Reset (asynchronous on rst_n=0):
  - state=IDLE, slct=2'b00, grant=0, mem_req=0, ack=0, err=0, busy=0.
  - last=2'd3, so requester 0 has highest priority first.
- All outputs are registered; there is no combinational path from any input to any output.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner i: the first set bit searching last+1, last+2, ... modulo 4.
  - At the next edge: state=ISSUE, slct=i, grant=1<<i, mem_req=1, busy=1.
  - Latency from req high to mem_req high is 1 cycle.
- ISSUE:
  - slct, grant and mem_req are held constant.
  - A req bit dropping during ISSUE, including the winner's, is ignored; the transaction completes.
  - When mem_ack is sampled high, at the next edge: state=RELEASE, mem_req=0, grant=0, ack=1<<i, last=i.
  - slct keeps the value i through RELEASE and IDLE and changes only on the next grant.
  - mem_ack is accepted even in the first ISSUE cycle, giving a minimum 1-cycle memory latency.
- RELEASE:
  - Lasts exactly one cycle; ack is high during it. No arbitration happens in this cycle.
  - The requester deasserts req on the edge after it sees ack.
  - Next edge: state=IDLE, ack=0, busy=0.
- Transaction spacing:
  - Minimum period per transaction is 3 cycles (ISSUE, RELEASE, IDLE) with a 1-cycle mem_ack.
  - With all four req bits held, grants rotate 0, 1, 2, 3, 0, ...
- mem_ack while in IDLE or RELEASE is ignored and produces no ack.
- Reset mid-transaction: all outputs return to their reset values immediately, and any outstanding memory access is abandoned. The memory side must tolerate mem_req dropping.
- Illegal state encodings recover to IDLE at the next edge with all outputs at their reset values.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entry to ISSUE and increments each ISSUE cycle while mem_ack is low.
  - When the count reaches TIMEOUT_CYCLES with mem_ack still low, the next edge enters RELEASE with ack=1<<i, err=1<<i and mem_req=0.
  - last=i, so the faulted requester loses priority.
  - If mem_ack is high in the same cycle the count reaches TIMEOUT_CYCLES, mem_ack wins and err=0.
- Disabled:
  - No counter is present and err is constant 0.
  - ISSUE waits for mem_ack indefinitely.

Test Plan:
- Reset values: hold rst_n=0 while req=4'b1111 → slct=0, grant=0, mem_req=0, ack=0, busy=0. Release rst_n → first grant is 4'b0001 one cycle later.
- Single requester, 3-cycle memory:
  - Stimulus: req=4'b0100 at cycle 0; mem_ack high in cycle 3 only.
  - Response: at edge 1 mem_req=1, slct=2'b10, grant=4'b0100. At edge 4 ack=4'b0100 for one cycle and mem_req=0. At edge 5 busy=0.
- Fairness: req=4'b1111 held, mem_ack tied to 1 → ack sequence 0001, 0010, 0100, 1000, 0001, with one ack every 3 cycles.
- Mid-transaction behaviour:
  - Winner drops req in ISSUE → transaction still completes with ack.
  - mem_ack pulsed while IDLE → no ack, no state change.
- Reset mid-ISSUE: assert rst_n=0 asynchronously mid-cycle → mem_req and grant drop before the next clock edge. After release, req=4'b1000 → grant=4'b1000.
- Timeout:
  - Stimulus: ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, req=4'b0010, mem_ack never asserted.
  - Response: ack=err=4'b0010 exactly 5 cycles after mem_req rises. With the macro undefined, mem_req stays high for more than 1000 cycles.
